// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 pipeline control path: opcodes, ALU operand
// select, ALU operation codes and the packed control bundle carried into EX.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   // funct3 of SRLI/SRAI: the only immediate op where bit 30 selects the variant
   localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   typedef enum logic [1:0] {
      ALU_SEL_REG = 2'b00,
      ALU_SEL_IMM = 2'b01,
      ALU_SEL_CMP = 2'b10
   } alu_sel_e;

   typedef struct packed {
      logic       valid;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      alu_sel_e   alu_sel;
      logic [3:0] alu_op;
      logic       wb_en;
      logic       wb_mux;
      logic [4:0] rd;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '{
      valid:     1'b0,
      branch:    1'b0,
      mem_read:  1'b0,
      mem_write: 1'b0,
      alu_sel:   ALU_SEL_REG,
      alu_op:    4'b0000,
      wb_en:     1'b0,
      wb_mux:    1'b0,
      rd:        5'd0
   };

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_BRANCH) || (opcode == OP_STORE);
   endfunction

endpackage

// File: rtl/rv_decoder.sv
// Purely combinational RV32 decode of the instruction sitting in decode into
// the EX control bundle, plus the register-source fields hazard logic needs.
module rv_decoder
   import rv_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            instr_valid,
   input  logic [XLEN-1:0] instr,
   output ctrl_t           ctrl,
   output logic            legal,
   output logic            rs2_used,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd_field;
   logic       bit30;

   assign opcode   = instr[6:0];
   assign rd_field = instr[11:7];
   assign funct3   = instr[14:12];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign bit30    = instr[30];
   assign rs2_used = uses_rs2(opcode);

   logic unused_bits;
   assign unused_bits = ^{instr[XLEN-1:31], instr[29:25]};

   // NOTE: every output of this block is given a default before the case so no
   // path leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      ctrl  = CTRL_BUBBLE;
      legal = 1'b0;
      case (opcode)
         OP_I_ALU: begin
            legal        = 1'b1;
            ctrl.alu_sel = ALU_SEL_IMM;
            ctrl.alu_op  = {(funct3 == F3_SHIFT_RIGHT) ? bit30 : 1'b0, funct3};
            ctrl.wb_en   = 1'b1;
            ctrl.rd      = rd_field;
         end
         OP_R: begin
            legal        = 1'b1;
            ctrl.alu_sel = ALU_SEL_REG;
            ctrl.alu_op  = {bit30, funct3};
            ctrl.wb_en   = 1'b1;
            ctrl.rd      = rd_field;
         end
         OP_BRANCH: begin
            legal        = 1'b1;
            ctrl.alu_sel = ALU_SEL_CMP;
            ctrl.alu_op  = ALU_SUB;
            ctrl.branch  = 1'b1;
         end
         OP_LOAD: begin
            legal         = 1'b1;
            ctrl.alu_sel  = ALU_SEL_IMM;
            ctrl.alu_op   = ALU_ADD;
            ctrl.mem_read = 1'b1;
            ctrl.wb_en    = 1'b1;
            ctrl.wb_mux   = 1'b1;
            ctrl.rd       = rd_field;
         end
         OP_STORE: begin
            legal          = 1'b1;
            ctrl.alu_sel   = ALU_SEL_IMM;
            ctrl.alu_op    = ALU_ADD;
            ctrl.mem_write = 1'b1;
         end
         default: ;
      endcase
      // Non-writing instructions carry rd 0 so a stale encoding field never
      // looks like a destination downstream.
      ctrl.valid = instr_valid && legal;
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32 pipeline control path: decode into EX, unconditional EX->MEM->WB
// advance, load-use stall detection, branch flush and a saturating stall count.
module pipelined_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ALU_CTRL_W = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   input  logic [XLEN-1:0]       instr,
   input  logic                  flush,
   output logic                  stall_out,
   output logic                  ex_valid,
   output logic                  ex_branch,
   output logic                  ex_mem_read,
   output logic [1:0]            ex_alu_sel,
   output logic [ALU_CTRL_W-1:0] ex_alu_control,
   output logic [4:0]            ex_rd,
   output logic                  mem_valid,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [4:0]            mem_rd,
   output logic                  wb_valid,
   output logic                  wb_en,
   output logic                  wb_mux,
   output logic [4:0]            wb_rd,
   output logic                  illegal,
   output logic [CNT_W-1:0]      stall_cnt
);

   ctrl_t      dec_ctrl;
   logic       dec_legal;
   logic       dec_rs2_used;
   logic [4:0] dec_rs1;
   logic [4:0] dec_rs2;

   rv_decoder #(
      .XLEN(XLEN)
   ) u_decoder (
      .instr_valid (instr_valid),
      .instr       (instr),
      .ctrl        (dec_ctrl),
      .legal       (dec_legal),
      .rs2_used    (dec_rs2_used),
      .rs1         (dec_rs1),
      .rs2         (dec_rs2)
   );

   ctrl_t ex_q;
   ctrl_t ex_d;
   logic  load_use;
   logic  illegal_d;
   logic  mem_wb_en;
   logic  mem_wb_mux;

   // A load in EX has no data until MEM, so a dependent instruction in decode
   // must wait one cycle. Flush discards decode entirely and so never stalls.
   always_comb begin
      load_use  = instr_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                  ((ex_q.rd == dec_rs1) || (dec_rs2_used && (ex_q.rd == dec_rs2)));
      stall_out = load_use && !flush;
      ex_d      = (dec_ctrl.valid && !stall_out && !flush) ? dec_ctrl : CTRL_BUBBLE;
      illegal_d = instr_valid && !dec_legal && !stall_out && !flush;
   end

   // NOTE: pipeline state uses non-blocking assignments so each stage captures
   // its predecessor's value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q       <= CTRL_BUBBLE;
         mem_valid  <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_rd     <= 5'd0;
         mem_wb_en  <= 1'b0;
         mem_wb_mux <= 1'b0;
         wb_valid   <= 1'b0;
         wb_en      <= 1'b0;
         wb_mux     <= 1'b0;
         wb_rd      <= 5'd0;
         illegal    <= 1'b0;
      end else begin
         ex_q       <= ex_d;
         mem_valid  <= ex_q.valid;
         mem_read   <= ex_q.mem_read;
         mem_write  <= ex_q.mem_write;
         mem_rd     <= ex_q.rd;
         mem_wb_en  <= ex_q.wb_en;
         mem_wb_mux <= ex_q.wb_mux;
         wb_valid   <= mem_valid;
         wb_en      <= mem_wb_en;
         wb_mux     <= mem_wb_mux;
         wb_rd      <= mem_rd;
         illegal    <= illegal_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_out && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign ex_valid       = ex_q.valid;
   assign ex_branch      = ex_q.branch;
   assign ex_mem_read    = ex_q.mem_read;
   assign ex_alu_sel     = ex_q.alu_sel;
   assign ex_alu_control = ALU_CTRL_W'(ex_q.alu_op);
   assign ex_rd          = ex_q.rd;

endmodule
